// File: rtl/gbp_update_ctrl.sv
// Global branch predictor update scheduler and flush sequencer.
// Two requesters feed a small FIFO that drains one update per cycle into the
// table write port. This block owns the global history register. A flush runs
// a row-by-row clear walk.
// Optional perf counters are built only when GBP_CTRL_PERF_EN is defined.
module gbp_update_ctrl #(
  parameter int unsigned  NR_ROWS         = 512,
  parameter int unsigned  INSTR_PER_FETCH = 2,
  parameter int unsigned  GHR_BITS        = 9,
  parameter int unsigned  FIFO_DEPTH      = 4,
  localparam int unsigned IDX_W           = $clog2(NR_ROWS),
  localparam int unsigned COL_W           = (INSTR_PER_FETCH > 2) ? $clog2(INSTR_PER_FETCH) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_bp_i,
  input  logic                debug_mode_i,
  input  logic                upd0_valid_i,
  output logic                upd0_ready_o,
  input  logic [IDX_W-1:0]    upd0_index_i,
  input  logic [COL_W-1:0]    upd0_col_i,
  input  logic                upd0_taken_i,
  input  logic                upd1_valid_i,
  output logic                upd1_ready_o,
  input  logic [IDX_W-1:0]    upd1_index_i,
  input  logic [COL_W-1:0]    upd1_col_i,
  input  logic                upd1_taken_i,
  output logic                tbl_we_o,
  output logic                tbl_clear_o,
  output logic [IDX_W-1:0]    tbl_waddr_o,
  output logic [COL_W-1:0]    tbl_wcol_o,
  output logic                tbl_taken_o,
  output logic [GHR_BITS-1:0] ghr_o,
  output logic                busy_o,
  output logic [31:0]         perf_writes_o,
  output logic [31:0]         perf_drops_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic [COL_W-1:0] col;
    logic             taken;
  } upd_t;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     clr_ptr_q, clr_ptr_d;
  upd_t                 fifo_q [FIFO_DEPTH];
  upd_t                 fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [GHR_BITS-1:0]  ghr_q, ghr_d;
  logic                 tbl_we_q, tbl_we_d;
  logic                 tbl_clear_q, tbl_clear_d;
  logic [IDX_W-1:0]     tbl_waddr_q, tbl_waddr_d;
  logic [COL_W-1:0]     tbl_wcol_q, tbl_wcol_d;
  logic                 tbl_taken_q, tbl_taken_d;
  logic                 busy_q, busy_d;
  logic                 push0, push1, pop;
  upd_t                 head, entry0, entry1;

  assign entry0 = '{index: upd0_index_i, col: upd0_col_i, taken: upd0_taken_i};
  assign entry1 = '{index: upd1_index_i, col: upd1_col_i, taken: upd1_taken_i};

  // Admission: readies depend only on registered occupancy, never on a same-cycle pop
  always_comb begin
    upd0_ready_o = 1'b0;
    upd1_ready_o = 1'b0;
    if (state_q == ST_RUN && !flush_bp_i) begin
      upd0_ready_o = (count_q < CNT_W'(FIFO_DEPTH));
      upd1_ready_o = (count_q <= CNT_W'(FIFO_DEPTH - 2)) ||
                     ((count_q == CNT_W'(FIFO_DEPTH - 1)) && !upd0_valid_i);
    end
  end

  // Next state: clear walk, FIFO push/pop, table write and GHR shift
  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    fifo_d      = fifo_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    ghr_d       = ghr_q;
    tbl_we_d    = 1'b0;
    tbl_clear_d = 1'b0;
    tbl_waddr_d = tbl_waddr_q;
    tbl_wcol_d  = tbl_wcol_q;
    tbl_taken_d = tbl_taken_q;
    busy_d      = (state_q == ST_CLEAR);
    push0       = upd0_valid_i && upd0_ready_o;
    push1       = upd1_valid_i && upd1_ready_o;
    pop         = 1'b0;
    head        = fifo_q[rd_ptr_q];

    if (flush_bp_i) begin
      // Flush wins over everything: drop queue, history and any pending write
      state_d   = ST_CLEAR;
      clr_ptr_d = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
      ghr_d     = '0;
      busy_d    = 1'b1;
    end else begin
      unique case (state_q)
        ST_CLEAR: begin
          tbl_we_d    = 1'b1;
          tbl_clear_d = 1'b1;
          tbl_waddr_d = clr_ptr_q;
          tbl_wcol_d  = '0;
          tbl_taken_d = 1'b0;
          rd_ptr_d    = '0;
          wr_ptr_d    = '0;
          count_d     = '0;
          clr_ptr_d   = clr_ptr_q + IDX_W'(1);
          if (clr_ptr_q == IDX_W'(NR_ROWS - 1)) begin
            state_d   = ST_RUN;
            clr_ptr_d = '0;
          end
        end
        ST_RUN: begin
          pop = (count_q != '0);
          if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (!debug_mode_i) begin
              tbl_we_d    = 1'b1;
              tbl_waddr_d = head.index;
              tbl_wcol_d  = head.col;
              tbl_taken_d = head.taken;
              ghr_d       = {ghr_q[GHR_BITS-2:0], head.taken};
            end
          end
          if (push0) fifo_d[wr_ptr_q] = entry0;
          if (push1) fifo_d[wr_ptr_q + PTR_W'(push0)] = entry1;
          wr_ptr_d = wr_ptr_q + PTR_W'(push0) + PTR_W'(push1);
          count_d  = count_q + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_CLEAR;
      clr_ptr_q   <= '0;
      fifo_q      <= '{default: '0};
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      ghr_q       <= '0;
      tbl_we_q    <= 1'b0;
      tbl_clear_q <= 1'b0;
      tbl_waddr_q <= '0;
      tbl_wcol_q  <= '0;
      tbl_taken_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      fifo_q      <= fifo_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      ghr_q       <= ghr_d;
      tbl_we_q    <= tbl_we_d;
      tbl_clear_q <= tbl_clear_d;
      tbl_waddr_q <= tbl_waddr_d;
      tbl_wcol_q  <= tbl_wcol_d;
      tbl_taken_q <= tbl_taken_d;
      busy_q      <= busy_d;
    end
  end

  assign tbl_we_o    = tbl_we_q;
  assign tbl_clear_o = tbl_clear_q;
  assign tbl_waddr_o = tbl_waddr_q;
  assign tbl_wcol_o  = tbl_wcol_q;
  assign tbl_taken_o = tbl_taken_q;
  assign ghr_o       = ghr_q;
  assign busy_o      = busy_q;

`ifdef GBP_CTRL_PERF_EN
  logic [31:0] perf_writes_q, perf_writes_d;
  logic [31:0] perf_drops_q, perf_drops_d;
  logic        upd_write, upd_drop;

  assign upd_write = tbl_we_d && !tbl_clear_d;
  assign upd_drop  = pop && debug_mode_i;

  // Saturating counters; only reset clears them
  always_comb begin
    perf_writes_d = perf_writes_q;
    perf_drops_d  = perf_drops_q;
    if (upd_write && (perf_writes_q != 32'hFFFF_FFFF)) perf_writes_d = perf_writes_q + 32'd1;
    if (upd_drop && (perf_drops_q != 32'hFFFF_FFFF))   perf_drops_d  = perf_drops_q + 32'd1;
  end

  // Perf counter registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_writes_q <= '0;
      perf_drops_q  <= '0;
    end else begin
      perf_writes_q <= perf_writes_d;
      perf_drops_q  <= perf_drops_d;
    end
  end

  assign perf_writes_o = perf_writes_q;
  assign perf_drops_o  = perf_drops_q;
`else
  assign perf_writes_o = '0;
  assign perf_drops_o  = '0;
`endif

endmodule

// File: tb/tb_gbp_update_ctrl.sv
// Scoreboard bench for gbp_update_ctrl: a queue-based model predicts each
// cycle's table activity, a monitor compares it with what the DUT shows.
module tb_gbp_update_ctrl;

  localparam int NR_ROWS  = 512;
  localparam int GHR_BITS = 9;
  localparam int DEPTH    = 4;
  localparam int IDX_W    = 9;
  localparam int COL_W    = 1;
`ifdef GBP_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  logic               flush_bp_i = 1'b0;
  logic               debug_mode_i = 1'b0;
  logic               upd0_valid_i = 1'b0, upd1_valid_i = 1'b0;
  logic               upd0_ready_o, upd1_ready_o;
  logic [IDX_W-1:0]   upd0_index_i = '0, upd1_index_i = '0;
  logic [COL_W-1:0]   upd0_col_i = '0, upd1_col_i = '0;
  logic               upd0_taken_i = 1'b0, upd1_taken_i = 1'b0;
  logic               tbl_we_o, tbl_clear_o, tbl_taken_o, busy_o;
  logic [IDX_W-1:0]   tbl_waddr_o;
  logic [COL_W-1:0]   tbl_wcol_o;
  logic [GHR_BITS-1:0] ghr_o;
  logic [31:0]        perf_writes_o, perf_drops_o;

  gbp_update_ctrl #(
    .NR_ROWS(NR_ROWS), .INSTR_PER_FETCH(2), .GHR_BITS(GHR_BITS), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_bp_i(flush_bp_i), .debug_mode_i(debug_mode_i),
    .upd0_valid_i(upd0_valid_i), .upd0_ready_o(upd0_ready_o), .upd0_index_i(upd0_index_i),
    .upd0_col_i(upd0_col_i), .upd0_taken_i(upd0_taken_i),
    .upd1_valid_i(upd1_valid_i), .upd1_ready_o(upd1_ready_o), .upd1_index_i(upd1_index_i),
    .upd1_col_i(upd1_col_i), .upd1_taken_i(upd1_taken_i),
    .tbl_we_o(tbl_we_o), .tbl_clear_o(tbl_clear_o), .tbl_waddr_o(tbl_waddr_o),
    .tbl_wcol_o(tbl_wcol_o), .tbl_taken_o(tbl_taken_o), .ghr_o(ghr_o), .busy_o(busy_o),
    .perf_writes_o(perf_writes_o), .perf_drops_o(perf_drops_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit clear;
    int addr;
    int col;
    bit taken;
  } wr_t;

  typedef struct {
    bit     we;
    bit     busy;
    int     ghr;
    longint writes;
    longint drops;
  } st_t;

  wr_t    wr_q[$];
  st_t    st_q[$];
  wr_t    fifo_m[$];
  int     rows_left, next_row, ghr_m;
  longint writes_m, drops_m;
  int     checks = 0;
  int     errors = 0;

  function automatic void chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
    end
  endfunction

  task automatic model_reset();
    rows_left = NR_ROWS;
    next_row  = 0;
    fifo_m.delete();
    ghr_m     = 0;
    writes_m  = 0;
    drops_m   = 0;
  endtask

  // Drive one cycle and predict what the DUT shows after the next rising edge
  task automatic cyc(input bit rst, input bit flush, input bit dbg, input bit v0, input bit v1,
                     input int i0, input int c0, input int t0,
                     input int i1, input int c1, input int t1);
    st_t st;
    wr_t e;
    int  free;
    bit  r0, r1;
    @(negedge clk_i);
    rst_ni       = rst;
    flush_bp_i   = flush;
    debug_mode_i = dbg;
    upd0_valid_i = v0;
    upd1_valid_i = v1;
    upd0_index_i = IDX_W'(i0);
    upd0_col_i   = COL_W'(c0);
    upd0_taken_i = t0[0];
    upd1_index_i = IDX_W'(i1);
    upd1_col_i   = COL_W'(c1);
    upd1_taken_i = t1[0];
    #1;
    st.we = 1'b0; st.busy = 1'b1; st.ghr = 0; st.writes = 0; st.drops = 0;
    if (!rst) begin
      model_reset();
      chk("rst_ready0", upd0_ready_o, 0);
      chk("rst_ready1", upd1_ready_o, 0);
      chk("rst_busy_now", busy_o, 1);
      chk("rst_we_now", tbl_we_o, 0);
      chk("rst_ghr_now", ghr_o, 0);
      st_q.push_back(st);
      return;
    end
    r0 = 1'b0; r1 = 1'b0;
    if (!flush && rows_left == 0) begin
      free = DEPTH - fifo_m.size();
      r0 = (free >= 1);
      r1 = (free >= 2) || (free == 1 && !v0);
    end
    chk("ready0", upd0_ready_o, r0);
    chk("ready1", upd1_ready_o, r1);
    st.busy = flush || (rows_left > 0);
    if (flush) begin
      fifo_m.delete();
      ghr_m = 0;
      rows_left = NR_ROWS;
      next_row = 0;
    end else if (rows_left > 0) begin
      st.we = 1'b1;
      e.clear = 1'b1; e.addr = next_row; e.col = 0; e.taken = 1'b0;
      wr_q.push_back(e);
      next_row++;
      rows_left--;
    end else begin
      if (fifo_m.size() > 0) begin
        e = fifo_m.pop_front();
        if (!dbg) begin
          st.we = 1'b1;
          ghr_m = ((ghr_m << 1) | int'(e.taken)) & ((1 << GHR_BITS) - 1);
          if (writes_m != 64'hFFFF_FFFF) writes_m++;
          wr_q.push_back(e);
        end else if (drops_m != 64'hFFFF_FFFF) begin
          drops_m++;
        end
      end
      if (v0 && r0) begin
        e.clear = 1'b0; e.addr = i0 % NR_ROWS; e.col = c0 % 2; e.taken = t0[0];
        fifo_m.push_back(e);
      end
      if (v1 && r1) begin
        e.clear = 1'b0; e.addr = i1 % NR_ROWS; e.col = c1 % 2; e.taken = t1[0];
        fifo_m.push_back(e);
      end
    end
    st.ghr    = ghr_m;
    st.writes = writes_m;
    st.drops  = drops_m;
    st_q.push_back(st);
  endtask

  task automatic rcyc(input bit flush, input bit dbg, input bit v0, input bit v1);
    cyc(1'b1, flush, dbg, v0, v1,
        int'($urandom_range(0, NR_ROWS - 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
        int'($urandom_range(0, NR_ROWS - 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) rcyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compares status every cycle, pops the write scoreboard on each strobe
  initial begin
    st_t st;
    wr_t w;
    @(negedge clk_i);
    forever begin
      @(posedge clk_i);
      #2;
      if (st_q.size() == 0) begin
        if (tbl_we_o) chk("unexpected_we", tbl_we_o, 0);
      end else begin
        st = st_q.pop_front();
        chk("we", tbl_we_o, st.we);
        chk("busy", busy_o, st.busy);
        chk("ghr", ghr_o, st.ghr);
        chk("perf_writes", perf_writes_o, PERF ? st.writes : 0);
        chk("perf_drops", perf_drops_o, PERF ? st.drops : 0);
        if (tbl_we_o) begin
          if (wr_q.size() == 0) begin
            chk("write_expected", 0, 1);
          end else begin
            w = wr_q.pop_front();
            chk("wr_clear", tbl_clear_o, w.clear);
            chk("wr_addr", tbl_waddr_o, w.addr);
            if (!w.clear) begin
              chk("wr_col", tbl_wcol_o, w.col);
              chk("wr_taken", tbl_taken_o, w.taken);
            end
          end
        end
      end
    end
  end

  initial begin
    model_reset();
    // Reset, then a full clear walk
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
    idle(NR_ROWS + 3);
    // Single update on port 0
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5, 1, 1, 0, 0, 0);
    idle(3);
    // Both ports valid every cycle: back-pressure and ordering
    for (int k = 0; k < 300; k++) rcyc(1'b0, 1'b0, 1'b1, 1'b1);
    // Entries queued, then a single-cycle flush and a fresh walk
    for (int k = 0; k < 3; k++) rcyc(1'b0, 1'b0, 1'b1, 1'b1);
    rcyc(1'b1, 1'b0, 1'b0, 1'b0);
    idle(NR_ROWS + 3);
    // Two entries drained with debug mode high
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 17, 0, 1, 33, 1, 1);
    for (int k = 0; k < 4; k++) rcyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    // Flush held several cycles with traffic presented
    for (int k = 0; k < 3; k++) rcyc(1'b1, 1'b0, 1'b1, 1'b1);
    idle(200);
    // Reset pulsed mid-walk, then a full walk
    for (int k = 0; k < 2; k++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 0, 0, 0, 0);
    idle(NR_ROWS + 3);
    // Mixed random traffic with debug and rare flushes
    for (int k = 0; k < 2500; k++) begin
      bit f;
      f = ($urandom_range(0, 599) == 0);
      rcyc(f, f ? 1'b0 : ($urandom_range(0, 7) == 0), $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0);
    end
    idle(NR_ROWS + 10);
    @(posedge clk_i);
    #4;
    chk("wr_queue_left", wr_q.size(), 0);
    chk("status_queue_left", st_q.size(), 0);
    chk("model_fifo_left", fifo_m.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gbp_update_ctrl.md
# gbp_update_ctrl

Update scheduler and flush sequencer for the global branch predictor counter table. It accepts resolved-branch updates from two execute-side requesters through valid/ready handshakes and buffers them in a FIFO. It drains them one per cycle into the table's single write port and owns the global history register (GHR) that the frontend XORs into the prediction index. A flush becomes a multi-cycle row-by-row clear walk instead of a single-cycle reset of the whole array.

## Interface
Parameters:
- `NR_ROWS`, default 512: counter table rows; `IDX_W = $clog2(NR_ROWS)`.
- `INSTR_PER_FETCH`, default 2: columns per row; `COL_W = max(1, $clog2(INSTR_PER_FETCH))`.
- `GHR_BITS`, default 9: global history length; legal range 2..IDX_W.
- `FIFO_DEPTH`, default 4: update buffer entries; must be a power of 2, at least 2.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `flush_bp_i` in 1: request a table clear.
- `debug_mode_i` in 1: debug mode; updates are discarded while it is high.
- `upd0_valid_i` / `upd1_valid_i` in 1: requester has an update.
- `upd0_ready_o` / `upd1_ready_o` out 1: update accepted this cycle when valid and ready are both high.
- `upd0_index_i` / `upd1_index_i` in IDX_W: table row, already hashed with GHR by the frontend.
- `upd0_col_i` / `upd1_col_i` in COL_W: column within the row.
- `upd0_taken_i` / `upd1_taken_i` in 1: resolved direction.
- `tbl_we_o` out 1: table write strobe.
- `tbl_clear_o` out 1: the write is a whole-row clear (valid=0, counter=weakly-taken) and ignores the column.
- `tbl_waddr_o` out IDX_W: row being written.
- `tbl_wcol_o` out COL_W: column being written.
- `tbl_taken_o` out 1: direction for the counter increment or decrement.
- `ghr_o` out GHR_BITS: global history.
- `busy_o` out 1: clear walk in progress; the frontend treats predictions as invalid.
- `perf_writes_o` out 32: count of update writes.
- `perf_drops_o` out 32: count of dropped updates.

## Operation
- FSM has two states: CLEAR and RUN. The reset state is CLEAR with clear pointer = 0.
- CLEAR:
  - Issues one clear write per cycle, pointer 0 to NR_ROWS-1 ascending.
  - Both readies are 0.
  - The FIFO is held empty.
  - After row NR_ROWS-1 the FSM moves to RUN.
- RUN admission, based on free = FIFO_DEPTH - count as registered at the start of the cycle:
  - `upd0_ready_o = (free >= 1)`.
  - `upd1_ready_o = (free >= 2) || (free == 1 && !upd0_valid_i)`.
  - When both requests are accepted in the same cycle, port 0 is enqueued ahead of port 1.
  - A pop in the same cycle does not raise free; there is no bypass.
- RUN drain: when the FIFO is non-empty, pop the head every cycle.
  - If `debug_mode_i` is low at the pop, issue an update write (`tbl_clear_o=0`) and shift `ghr <= {ghr[GHR_BITS-2:0], taken}`.
  - If it is high, discard the entry: no write, no GHR change, `perf_drops_o` increments.
- Flush in RUN or CLEAR, with `flush_bp_i` sampled high at a clock edge:
  - Discard all FIFO contents.
  - Clear GHR to 0.
  - Cancel any write registered at that same edge.
  - Restart CLEAR at pointer 0.
  - Readies are forced to 0 in the flush cycle itself, so no handshake completes then.
- Flush held high for several cycles keeps restarting pointer 0. The walk completes NR_ROWS cycles after the last flush cycle.
- Reset asserted mid-walk or mid-drain: all state returns to its reset values immediately.

## Timing
- All `tbl_*` outputs, `ghr_o`, `busy_o` and the perf counters are registered.
- Reset values:
  - `busy_o = 1`.
  - Every other output = 0, including `ghr_o` and both perf counters.
  - The readies are 0 because the FSM is in CLEAR.
- Clear walk: `tbl_we_o=tbl_clear_o=1` for exactly NR_ROWS consecutive cycles, starting the first cycle after the first clock edge with `rst_ni` high (or after the flush edge). `busy_o` falls in the cycle after the last clear write.
- Update latency: handshake at edge E puts the entry at the FIFO head after E; `tbl_we_o` for that entry is visible after edge E+1. `ghr_o` reflects the shift after that same edge E+1.
- Sustained throughput is one write per cycle. `tbl_we_o` is a single-cycle pulse per entry.

## Configuration
- `GBP_CTRL_PERF_EN` defined:
  - `perf_writes_o` counts update writes (not clear writes).
  - `perf_drops_o` counts debug-mode discards.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and clear only on reset (flush does not clear them).
- Undefined: both ports are tied to 0 and no counter flops are built.

## Test plan
- Reset with NR_ROWS=512, release -> `busy_o=1`; 512 clear writes with `tbl_waddr_o` 0..511; `busy_o=0` on cycle 513; `ghr_o=0`.
- After the walk, `upd0` {idx=5, col=1, taken=1} -> after 2 edges `tbl_we_o=1`, `tbl_waddr_o=5`, `tbl_wcol_o=1`, `tbl_taken_o=1`, `ghr_o=1`.
- Both ports valid every cycle with FIFO_DEPTH=4, drain active -> port 0 entries always precede port 1; no entry is lost; readies drop to 0 when count reaches 4 and stay low until the next pop.
- Three entries queued, then `flush_bp_i` for 1 cycle -> no further update writes; `ghr_o=0`; a 512-row clear walk restarts at row 0.
- `debug_mode_i=1` while 2 entries drain -> no `tbl_we_o`, `ghr_o` unchanged, `perf_drops_o=2` (with `GBP_CTRL_PERF_EN`), FIFO empty.
- `rst_ni` pulsed low at clear row 200 -> outputs return to reset values; the walk restarts from row 0 after release.
